f32_addsub_sched: RTL and testbench

- Shares one f32 subtract datapath (out = x - y, combinational or pipelined) among N requesters.
- Round-robin arbitration; at most one issue per cycle.
- Add is implemented by flipping the sign of b; the subtract datapath is unchanged.
- In-flight ops are tracked by a tag shift register. Results are buffered in a credit-protected FIFO and returned on a single response port, tagged with the requester ID.

---
 rtl/f32_addsub_sched.sv | 128 ++++++++++++
 tb/tb_f32_addsub_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/f32_addsub_sched.sv
// f32_addsub_sched: round-robin scheduler sharing one f32 subtract datapath among N requesters.
// Optional F32_ADDSUB_SCHED_STATS_EN adds saturating issue/stall counters.
module f32_addsub_sched #(
    parameter int N_REQ      = 4,
    parameter int DP_LAT     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [32*N_REQ-1:0]        req_a,
    input  logic [32*N_REQ-1:0]        req_b,
    input  logic [N_REQ-1:0]           req_add,
    output logic [31:0]                dp_x,
    output logic [31:0]                dp_y,
    output logic                       dp_issue,
    input  logic [31:0]                dp_out,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [31:0]                rsp_data
`ifdef F32_ADDSUB_SCHED_STATS_EN
    ,
    output logic [31:0]                stat_issue_cnt,
    output logic [31:0]                stat_stall_cnt
`endif
);
    localparam int IDW = $clog2(N_REQ);
    localparam int AW  = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    logic [IDW-1:0] r_rr, w_g, w_k, w_push_id;
    logic           w_any, w_hs, w_pop, w_push;
    logic [CW-1:0]  r_out, r_cnt;
    logic [AW-1:0]  r_wp, r_rp;
    logic [31:0]    r_mem [FIFO_DEPTH];
    logic [IDW-1:0] r_mid [FIFO_DEPTH];

    // Descending scan so the closest index at or after r_rr wins.
    always_comb begin
        w_g   = r_rr;
        w_k   = r_rr;
        w_any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_k = IDW'((int'(r_rr) + i) % N_REQ);
            if (req_valid[w_k]) begin
                w_g   = w_k;
                w_any = 1'b1;
            end
        end
    end

    // A pop frees its credit only once r_out updates, so it is never reused in the same cycle.
    assign w_hs      = rst_n && w_any && (r_out < CW'(FIFO_DEPTH));
    assign req_ready = w_hs ? (N_REQ'(1) << w_g) : '0;
    assign dp_issue  = w_hs;
    assign dp_x      = w_hs ? req_a[32*w_g +: 32] : '0;
    assign dp_y      = w_hs ? (req_b[32*w_g +: 32] ^ {req_add[w_g], 31'b0}) : '0;
    assign rsp_valid = r_cnt != '0;
    assign rsp_data  = r_mem[r_rp];
    assign rsp_id    = r_mid[r_rp];
    assign w_pop     = rsp_valid && rsp_ready;

    generate
        if (DP_LAT == 0) begin : g_comb
            assign w_push    = w_hs;
            assign w_push_id = w_g;
        end else begin : g_pipe
            logic [DP_LAT-1:0] r_tv;
            logic [IDW-1:0]    r_tid [DP_LAT];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tv <= '0;
                    for (int i = 0; i < DP_LAT; i++) r_tid[i] <= '0;
                end else begin
                    r_tv[0]  <= w_hs;
                    r_tid[0] <= w_g;
                    for (int i = 1; i < DP_LAT; i++) begin
                        r_tv[i]  <= r_tv[i-1];
                        r_tid[i] <= r_tid[i-1];
                    end
                end
            end
            assign w_push    = r_tv[DP_LAT-1];
            assign w_push_id = r_tid[DP_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr  <= '0;
            r_out <= '0;
            r_cnt <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
                r_mid[i] <= '0;
            end
        end else begin
            if (w_hs) r_rr <= (w_g == IDW'(N_REQ - 1)) ? '0 : w_g + 1'b1;
            r_out <= r_out + CW'(w_hs) - CW'(w_pop);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (w_push) begin
                r_mem[r_wp] <= dp_out;
                r_mid[r_wp] <= w_push_id;
                r_wp        <= (r_wp == AW'(FIFO_DEPTH - 1)) ? '0 : r_wp + 1'b1;
            end
            if (w_pop) r_rp <= (r_rp == AW'(FIFO_DEPTH - 1)) ? '0 : r_rp + 1'b1;
        end
    end

`ifdef F32_ADDSUB_SCHED_STATS_EN
    logic [31:0] r_issue_cnt, r_stall_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_hs && r_issue_cnt != '1) r_issue_cnt <= r_issue_cnt + 1'b1;
            if (|req_valid && !w_hs && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
    assign stat_issue_cnt = r_issue_cnt;
    assign stat_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_f32_addsub_sched.sv
// tb_f32_addsub_sched: two DUTs (DP_LAT 0 and 2) on shared stimulus, checked against a queue-based model.
module tb_f32_addsub_sched;
    localparam int D = 4;

    typedef struct {
        int          k;
        logic [1:0]  id;
        logic [31:0] d;
        int          rc;
    } ent_t;

    logic         clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b1;
    logic [3:0]   vld = '0, add = '0;
    logic [127:0] a = '0, b = '0;
    logic [3:0]   rdy [2];
    logic [31:0]  dpx [2], dpy [2], dpo [2], rdat [2];
    logic         dpi [2], rv [2];
    logic [1:0]   rid [2];
    logic [31:0]  p0, p1;

    ent_t sb[$];
    int   rr_m [2];
    int   hs_cnt [2];
    int   cyc = 0, total = 0, bad = 0;

    always #5 clk = ~clk;

    function automatic real f2r(logic [31:0] x);
        logic [10:0] e;
        e = {3'b0, x[30:23]} + 11'd896;
        if (x[30:0] == 31'b0) return 0.0;
        return $bitstoreal({x[31], e, x[22:0], 29'b0});
    endfunction

    function automatic logic [31:0] r2f(real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (e <= 0) return {d[63], 31'b0};
        return {d[63], 8'(e), d[51:29]};
    endfunction

    // Stand-in datapath: x - y, with any Inf/NaN operand producing the canonical NaN.
    function automatic logic [31:0] fsub(logic [31:0] x, logic [31:0] y);
        if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return 32'h7FC00000;
        return r2f(f2r(x) - f2r(y));
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    assign dpo[0] = fsub(dpx[0], dpy[0]);
    always @(posedge clk) begin
        p0 <= fsub(dpx[1], dpy[1]);
        p1 <= p0;
    end
    assign dpo[1] = p1;

    f32_addsub_sched #(.N_REQ(4), .DP_LAT(0), .FIFO_DEPTH(D)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld), .req_ready(rdy[0]), .req_a(a), .req_b(b),
        .req_add(add), .dp_x(dpx[0]), .dp_y(dpy[0]), .dp_issue(dpi[0]), .dp_out(dpo[0]),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_id(rid[0]), .rsp_data(rdat[0]));

    f32_addsub_sched #(.N_REQ(4), .DP_LAT(2), .FIFO_DEPTH(D)) u2 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld), .req_ready(rdy[1]), .req_a(a), .req_b(b),
        .req_add(add), .dp_x(dpx[1]), .dp_y(dpy[1]), .dp_issue(dpi[1]), .dp_out(dpo[1]),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_id(rid[1]), .rsp_data(rdat[1]));

    task automatic chk(string t, logic [31:0] o, logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s cyc=%0d obs=%h exp=%h", t, cyc, o, e);
        end
    endtask

    task automatic tick();
        int h [2];
        int g [2];
        bit hs [2], pop [2], any, erv;
        int n;
        logic [31:0] ea, eb, ed [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            h[k] = -1;
            foreach (sb[i]) if (sb[i].k == k) begin
                if (h[k] < 0) h[k] = i;
                n++;
            end
            g[k] = rr_m[k];
            any = 1'b0;
            for (int i = 3; i >= 0; i--) if (vld[(rr_m[k] + i) % 4]) begin
                g[k] = (rr_m[k] + i) % 4;
                any = 1'b1;
            end
            hs[k] = any && n < D;
            ea = a[32*g[k] +: 32];
            eb = b[32*g[k] +: 32] ^ {add[g[k]], 31'b0};
            ed[k] = fsub(ea, eb);
            chk($sformatf("ready%0d", k), 32'(rdy[k]), hs[k] ? 32'(1) << g[k] : 32'd0);
            chk($sformatf("issue%0d", k), 32'(dpi[k]), 32'(hs[k]));
            chk($sformatf("dp_x%0d", k), dpx[k], hs[k] ? ea : 32'd0);
            chk($sformatf("dp_y%0d", k), dpy[k], hs[k] ? eb : 32'd0);
            erv = h[k] >= 0 && sb[h[k]].rc <= cyc;
            chk($sformatf("rsp_valid%0d", k), 32'(rv[k]), 32'(erv));
            if (erv) begin
                chk($sformatf("rsp_id%0d", k), 32'(rid[k]), 32'(sb[h[k]].id));
                chk($sformatf("rsp_data%0d", k), rdat[k], sb[h[k]].d);
            end
            pop[k] = erv && rsp_ready;
        end
        @(posedge clk);
        if (pop[0] && pop[1]) begin
            sb.delete(h[0] > h[1] ? h[0] : h[1]);
            sb.delete(h[0] > h[1] ? h[1] : h[0]);
        end else if (pop[0]) sb.delete(h[0]);
        else if (pop[1]) sb.delete(h[1]);
        for (int k = 0; k < 2; k++) if (hs[k]) begin
            sb.push_back('{k, 2'(g[k]), ed[k], cyc + (k == 0 ? 0 : 2) + 1});
            rr_m[k] = (g[k] + 1) % 4;
            hs_cnt[k]++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rnd_ops();
        for (int i = 0; i < 4; i++) begin
            a[32*i +: 32] = rnd_f();
            b[32*i +: 32] = rnd_f();
        end
        add = 4'($urandom);
    endtask

    task automatic chk_reset();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_rsp_valid%0d", k), 32'(rv[k]), 32'd0);
            chk($sformatf("rst_rsp_id%0d", k), 32'(rid[k]), 32'd0);
            chk($sformatf("rst_rsp_data%0d", k), rdat[k], 32'd0);
            chk($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd0);
            chk($sformatf("rst_issue%0d", k), 32'(dpi[k]), 32'd0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        rr_m = '{0, 0};
        cyc++;
    endtask

    initial begin
        int h0 [2];
        rr_m = '{0, 0};
        hs_cnt = '{0, 0};
        vld = 4'hF;
        #2;
        chk_reset();
        @(negedge clk);
        rst_n = 1'b1;
        vld = '0;
        // single subtract on requester 0: 3.0 - 1.0
        a[31:0] = 32'h40400000; b[31:0] = 32'h3F800000; add = 4'b0000; vld = 4'b0001;
        tick();
        vld = '0;
        ticks(5);
        // add through sign flip on requester 2: 1.0 + 1.0
        a[95:64] = 32'h3F800000; b[95:64] = 32'h3F800000; add = 4'b0100; vld = 4'b0100;
        tick();
        vld = '0;
        ticks(5);
        // Inf - Inf on requester 1
        a[63:32] = 32'h7F800000; b[63:32] = 32'h7F800000; add = 4'b0000; vld = 4'b0010;
        tick();
        vld = '0;
        ticks(5);
        // round robin with everyone requesting
        vld = 4'hF;
        for (int i = 0; i < 12; i++) begin
            rnd_ops();
            tick();
        end
        vld = '0;
        ticks(6);
        // credit exhaustion with the response port stalled
        h0 = hs_cnt;
        rsp_ready = 1'b0;
        vld = 4'hF;
        rnd_ops();
        ticks(8);
        for (int k = 0; k < 2; k++) chk($sformatf("credit_fill%0d", k), 32'(hs_cnt[k] - h0[k]), 32'd4);
        h0 = hs_cnt;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        ticks(3);
        for (int k = 0; k < 2; k++) chk($sformatf("credit_one%0d", k), 32'(hs_cnt[k] - h0[k]), 32'd1);
        vld = '0;
        rsp_ready = 1'b1;
        ticks(8);
        // random traffic and random backpressure
        for (int i = 0; i < 80; i++) begin
            vld = 4'($urandom);
            rsp_ready = 1'($urandom);
            rnd_ops();
            tick();
        end
        vld = '0;
        rsp_ready = 1'b1;
        ticks(10);
        // reset with ops in flight
        rsp_ready = 1'b0;
        vld = 4'hF;
        rnd_ops();
        ticks(3);
        do_reset();
        vld = '0;
        rsp_ready = 1'b1;
        ticks(5);
        h0 = hs_cnt;
        vld = 4'hF;
        rnd_ops();
        tick();
        vld = '0;
        ticks(6);
        for (int k = 0; k < 2; k++) chk($sformatf("post_reset_issue%0d", k), 32'(hs_cnt[k] - h0[k]), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
